// File: rtl/lfsr_seq_checker_if.sv
// Link-side bundle for the 4-bit LFSR sequence checker.
// Only the received-symbol path and the checker status live here; clk and reset stay plain ports.
interface lfsr_seq_checker_if #(
  parameter int ERR_CNT_W = 8
);
  // in_valid qualifies in_data for exactly one cycle. There is no ready:
  // the checker accepts every valid cycle, and in_valid=0 cycles are ignored.
  logic                 clr;
  logic                 in_valid;
  logic [3:0]           in_data;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [3:0]           seq_index;
  logic                 index_valid;
  logic [1:0]           dbg_state;

  modport master (
    output clr, in_valid, in_data,
    input  locked, err_pulse, err_count, seq_index, index_valid, dbg_state
  );

  modport slave (
    input  clr, in_valid, in_data,
    output locked, err_pulse, err_count, seq_index, index_valid, dbg_state
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 4-bit maximal-length LFSR stream (x^4+x^3+1, period 15).
// Locks onto the stream, flags and counts mispredictions, and decodes symbols to their index.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_seq_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

  state_e               state_q;
  logic [3:0]           pred_q;
  logic [3:0]           match_cnt_q;
  logic [3:0]           miss_cnt_q;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [3:0]           seq_index_q;
  logic                 index_valid_q;

  logic [3:0]           dec_index;
  logic                 dec_legal;
  logic                 hit;
  logic                 nonzero;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  assign nonzero   = (bus.in_data != 4'b0000);
  assign hit       = (bus.in_data == pred_q);
  assign dec_legal = nonzero;

  // Inverse of the counter-to-LFSR mapping; 0000 is not on the cycle.
  always_comb begin
    dec_index = 4'd0;
    case (bus.in_data)
      4'b0001: dec_index = 4'd0;
      4'b0010: dec_index = 4'd1;
      4'b0100: dec_index = 4'd2;
      4'b1001: dec_index = 4'd3;
      4'b0011: dec_index = 4'd4;
      4'b0110: dec_index = 4'd5;
      4'b1101: dec_index = 4'd6;
      4'b1010: dec_index = 4'd7;
      4'b0101: dec_index = 4'd8;
      4'b1011: dec_index = 4'd9;
      4'b0111: dec_index = 4'd10;
      4'b1111: dec_index = 4'd11;
      4'b1110: dec_index = 4'd12;
      4'b1100: dec_index = 4'd13;
      4'b1000: dec_index = 4'd14;
      default: dec_index = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      pred_q        <= 4'b0001;
      match_cnt_q   <= 4'd0;
      miss_cnt_q    <= 4'd0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
      seq_index_q   <= 4'd0;
      index_valid_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.clr) err_count_q <= '0;

      if (bus.in_valid) begin
        seq_index_q   <= dec_index;
        index_valid_q <= dec_legal;

        case (state_q)
          SEARCH: begin
            if (nonzero) begin
              pred_q      <= lfsr_next(bus.in_data);
              match_cnt_q <= 4'd0;
              state_q     <= VERIFY;
            end
          end

          VERIFY: begin
            if (hit) begin
              pred_q <= lfsr_next(bus.in_data);
              if (match_cnt_q == LOCK_LAST) begin
                state_q     <= LOCKED;
                locked_q    <= 1'b1;
                match_cnt_q <= 4'd0;
                miss_cnt_q  <= 4'd0;
              end else begin
                match_cnt_q <= match_cnt_q + 4'd1;
              end
            end else if (nonzero) begin
              pred_q      <= lfsr_next(bus.in_data);
              match_cnt_q <= 4'd0;
            end else begin
              match_cnt_q <= 4'd0;
              state_q     <= SEARCH;
            end
          end

          LOCKED: begin
            // Free-run on a miss so one corrupted symbol cannot knock the phase off.
            pred_q <= lfsr_next(pred_q);
            if (hit) begin
              miss_cnt_q <= 4'd0;
            end else begin
              err_pulse_q <= 1'b1;
              if (!bus.clr && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
              if (miss_cnt_q == LOSS_LAST) begin
                state_q    <= SEARCH;
                locked_q   <= 1'b0;
                miss_cnt_q <= 4'd0;
              end else begin
                miss_cnt_q <= miss_cnt_q + 4'd1;
              end
            end
          end

          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked      = locked_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_count   = err_count_q;
  assign bus.seq_index   = seq_index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, errors, loss of lock, saturation/clr,
// wrap-around with idle gaps, and asynchronous reset.
module tb_lfsr_seq_checker;

  localparam int ERR_CNT_W = 8;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  logic [3:0] exp_q[$];

  lfsr_seq_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  lfsr_seq_checker #(
    .LOCK_COUNT(4),
    .LOSS_COUNT(3),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one valid symbol at a negedge; returns at the next negedge with outputs settled.
  task automatic drive(input logic [3:0] sym, input logic clr_v = 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = sym;
    bus.clr      = clr_v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'b0000;
    @(negedge clk);
  endtask

  task automatic send_chk(input string tag, input logic [3:0] sym, input logic [3:0] e_idx,
                          input logic e_iv, input logic e_pulse, input logic e_locked);
    drive(sym);
    check_eq({tag, ".idx"},    32'(bus.seq_index),   32'(e_idx));
    check_eq({tag, ".iv"},     32'(bus.index_valid), 32'(e_iv));
    check_eq({tag, ".pulse"},  32'(bus.err_pulse),   32'(e_pulse));
    check_eq({tag, ".locked"}, 32'(bus.locked),      32'(e_locked));
  endtask

  task automatic lock_stream(input string tag);
    send_chk({tag, ".s0"}, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0);
    send_chk({tag, ".s1"}, 4'b0010, 4'd1, 1'b1, 1'b0, 1'b0);
    send_chk({tag, ".s2"}, 4'b0100, 4'd2, 1'b1, 1'b0, 1'b0);
    send_chk({tag, ".s3"}, 4'b1001, 4'd3, 1'b1, 1'b0, 1'b0);
    send_chk({tag, ".s4"}, 4'b0011, 4'd4, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] wrap_syms [11];
    logic [3:0] e_idx;
    n_checks = 0;
    n_fail   = 0;
    wrap_syms = '{4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                  4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010};

    reset        = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("rst.locked", 32'(bus.locked),      32'd0);
    check_eq("rst.pulse",  32'(bus.err_pulse),   32'd0);
    check_eq("rst.errcnt", 32'(bus.err_count),   32'd0);
    check_eq("rst.idx",    32'(bus.seq_index),   32'd0);
    check_eq("rst.iv",     32'(bus.index_valid), 32'd0);
    check_eq("rst.state",  32'(bus.dbg_state),   32'd0);
    reset = 1'b1;

    // 1: lock
    lock_stream("t1");
    check_eq("t1.errcnt", 32'(bus.err_count), 32'd0);

    // 2: one corrupted symbol; prediction free-runs so the following symbol still matches
    send_chk("t2.bad",  4'b1111, 4'd11, 1'b1, 1'b1, 1'b1);
    check_eq("t2.errcnt", 32'(bus.err_count), 32'd1);
    send_chk("t2.good", 4'b1101, 4'd6, 1'b1, 1'b0, 1'b1);
    check_eq("t2.errcnt2", 32'(bus.err_count), 32'd1);

    // 3: loss of lock after three misses
    send_chk("t3.m1", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b1);
    send_chk("t3.m2", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b1);
    send_chk("t3.m3", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0);
    check_eq("t3.errcnt", 32'(bus.err_count), 32'd4);
    check_eq("t3.state",  32'(bus.dbg_state), 32'd0);
    send_chk("t3.seed", 4'b0101, 4'd8, 1'b1, 1'b0, 1'b0);
    check_eq("t3.verify", 32'(bus.dbg_state), 32'd1);

    // 4: 87 relock/lose rounds add 261 errors on top of 4
    for (int r = 0; r < 87; r++) begin
      drive(4'b0000);
      drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1001); drive(4'b0011);
      drive(4'b0000); drive(4'b0000); drive(4'b0000);
    end
    check_eq("t4.sat",    32'(bus.err_count), 32'd255);
    check_eq("t4.locked", 32'(bus.locked),    32'd0);
    lock_stream("t4r");
    check_eq("t4.hold", 32'(bus.err_count), 32'd255);
    drive(4'b0000, 1'b1);
    check_eq("t4.clr.errcnt", 32'(bus.err_count), 32'd0);
    check_eq("t4.clr.pulse",  32'(bus.err_pulse), 32'd1);
    check_eq("t4.clr.locked", 32'(bus.locked),    32'd1);

    // 5: wrap 1000 -> 0001 with idle gaps between every symbol
    for (int i = 0; i < 11; i++) begin
      e_idx = 4'(6 + i);
      if (i >= 9) e_idx = 4'(i - 9);
      exp_q.push_back(e_idx);
    end
    foreach (wrap_syms[i]) begin
      logic [3:0] want;
      want = exp_q.pop_front();
      send_chk($sformatf("t5.s%0d", i), wrap_syms[i], want, 1'b1, 1'b0, 1'b1);
      idle();
      check_eq($sformatf("t5.gap%0d.idx", i),   32'(bus.seq_index), 32'(want));
      check_eq($sformatf("t5.gap%0d.pulse", i), 32'(bus.err_pulse), 32'd0);
      check_eq($sformatf("t5.gap%0d.lock", i),  32'(bus.locked),    32'd1);
    end
    check_eq("t5.errcnt", 32'(bus.err_count), 32'd0);

    // 6: asynchronous reset between edges
    send_chk("t6.bad", 4'b1111, 4'd11, 1'b1, 1'b1, 1'b1);
    check_eq("t6.errcnt", 32'(bus.err_count), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("t6.locked", 32'(bus.locked),      32'd0);
    check_eq("t6.errcnt0", 32'(bus.err_count),  32'd0);
    check_eq("t6.idx",    32'(bus.seq_index),   32'd0);
    check_eq("t6.iv",     32'(bus.index_valid), 32'd0);
    check_eq("t6.state",  32'(bus.dbg_state),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    lock_stream("t6r");
    check_eq("t6r.errcnt", 32'(bus.err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
